line_mem_arbiter: RTL and testbench

- Sequences and shares the single 64-bit-line instruction/data backing memory between the instruction-cache refill path and the data-cache refill/writeback path.
- Sits between both caches and the line memory.
- Accepts one line request at a time and holds it for the fixed memory latency.
- Returns the read line or a write acknowledge, and drives a busy flag the pipeline uses as a stall qualifier.

---
 rtl/line_mem_arbiter_if.sv | 31 +++
 rtl/line_mem_arbiter.sv | 108 ++++++++++
 tb/tb_line_mem_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_arbiter_if.sv
// line_mem_arbiter_if: cache request/response and line-memory signals around line_mem_arbiter.
interface line_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 64
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wline;
    logic              dc_done;
    logic [LINE_W-1:0] rd_line;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [LINE_W-1:0] mem_wline;
    logic [LINE_W-1:0] mem_rline;
    logic              busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_rline,
        output ic_done, dc_done, rd_line, mem_en, mem_we, mem_addr, mem_wline, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wline, mem_rline,
        input  ic_done, dc_done, rd_line, mem_en, mem_we, mem_addr, mem_wline, busy
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one line memory between I-cache refill and D-cache refill/writeback.
// LINE_ARB_ROUND_ROBIN_EN alternates tied grants; without it the D-cache always wins a tie.
module line_mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int LINE_W      = 64,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    line_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

`ifdef LINE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              own_dc_q, own_dc_d;
    logic              we_q, we_d;
    logic              last_dc_q, last_dc_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;
    logic              mem_en_q, mem_en_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              busy_q, busy_d;
    logic              grant_dc;

    // last_dc_q only steers ties when round robin is compiled in
    assign grant_dc = bus.dc_req && (!bus.ic_req || !RR || !last_dc_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_dc_d  = own_dc_q;
        we_d      = we_q;
        last_dc_d = last_dc_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rd_line_d = rd_line_q;
        case (state_q)
            IDLE: if (bus.ic_req || bus.dc_req) begin
                state_d   = BUSY;
                cnt_d     = 4'(MEM_LATENCY - 1);
                own_dc_d  = grant_dc;
                last_dc_d = grant_dc;
                we_d      = grant_dc && bus.dc_we;
                addr_d    = grant_dc ? bus.dc_addr[ADDR_W-1:2] : bus.ic_addr[ADDR_W-1:2];
                wline_d   = bus.dc_wline;
            end
            BUSY: if (cnt_q == 4'd0) begin
                state_d   = RESP;
                rd_line_d = we_q ? rd_line_q : bus.mem_rline;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        mem_en_d  = state_d == BUSY;
        busy_d    = state_d != IDLE;
        ic_done_d = state_d == RESP && !own_dc_d;
        dc_done_d = state_d == RESP && own_dc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            own_dc_q  <= 1'b0;
            we_q      <= 1'b0;
            last_dc_q <= 1'b1;
            addr_q    <= '0;
            wline_q   <= '0;
            rd_line_q <= '0;
            mem_en_q  <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_dc_q  <= own_dc_d;
            we_q      <= we_d;
            last_dc_q <= last_dc_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            rd_line_q <= rd_line_d;
            mem_en_q  <= mem_en_d;
            ic_done_q <= ic_done_d;
            dc_done_q <= dc_done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ic_done   = ic_done_q;
    assign bus.dc_done   = dc_done_q;
    assign bus.rd_line   = rd_line_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wline = wline_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed and randomized checks of line_mem_arbiter at MEM_LATENCY 1, 2 and 3.
module tb_line_mem_arbiter;
`ifdef LINE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req[3], dc_req[3], dc_we[3];
    logic [15:0] ic_addr[3], dc_addr[3];
    logic [63:0] dc_wline[3], mem_rline[3];
    logic        ic_done[3], dc_done[3], mem_en[3], mem_we[3], busy[3];
    logic [13:0] mem_addr[3];
    logic [63:0] mem_wline[3], rd_line[3];
    logic [63:0] env_mem[3][256];
    bit          env_v[3][256];
    logic [1:0]  en_cnt[3];
    logic [63:0] mdl_mem[3][256];
    bit          mdl_v[3][256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        line_mem_arbiter_if #(.ADDR_W(16), .LINE_W(64)) bus ();
        line_mem_arbiter #(.MEM_LATENCY(k + 1), .LINE_W(64), .ADDR_W(16)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
        assign bus.ic_req    = ic_req[k];
        assign bus.ic_addr   = ic_addr[k];
        assign bus.dc_req    = dc_req[k];
        assign bus.dc_we     = dc_we[k];
        assign bus.dc_addr   = dc_addr[k];
        assign bus.dc_wline  = dc_wline[k];
        assign bus.mem_rline = mem_rline[k];
        assign ic_done[k]    = bus.ic_done;
        assign dc_done[k]    = bus.dc_done;
        assign rd_line[k]    = bus.rd_line;
        assign mem_en[k]     = bus.mem_en;
        assign mem_we[k]     = bus.mem_we;
        assign mem_addr[k]   = bus.mem_addr;
        assign mem_wline[k]  = bus.mem_wline;
        assign busy[k]       = bus.busy;
    end

    function automatic logic [63:0] pattern(logic [13:0] a);
        return {2'b01, a, 2'b10, ~a, 2'b11, a ^ 14'h2AAA, 2'b00, a + 14'd77};
    endfunction

    function automatic logic [63:0] env_rd(int k, logic [13:0] a);
        return env_v[k][a[7:0]] ? env_mem[k][a[7:0]] : pattern(a);
    endfunction

    function automatic logic [63:0] mdl_rd(int k, logic [13:0] a);
        return mdl_v[k][a[7:0]] ? mdl_mem[k][a[7:0]] : pattern(a);
    endfunction

    // Line memory: read data is only valid in the last latency cycle, writes land on that cycle.
    always @(posedge clk)
        for (int k = 0; k < 3; k++) begin
            en_cnt[k] <= mem_en[k] ? en_cnt[k] + 2'd1 : 2'd0;
            if (mem_en[k] && mem_we[k] && en_cnt[k] == 2'(k)) begin
                env_mem[k][mem_addr[k][7:0]] <= mem_wline[k];
                env_v[k][mem_addr[k][7:0]]   <= 1'b1;
            end
        end

    always @(negedge clk)
        for (int k = 0; k < 3; k++)
            mem_rline[k] <= (mem_en[k] && en_cnt[k] == 2'(k)) ? env_rd(k, mem_addr[k]) : ~env_rd(k, mem_addr[k]);

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            ic_req[k]   = 1'b0;
            dc_req[k]   = 1'b0;
            dc_we[k]    = 1'b0;
            ic_addr[k]  = '0;
            dc_addr[k]  = '0;
            dc_wline[k] = '0;
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy[k], mem_en[k], mem_we[k], ic_done[k], dc_done[k]} !== 5'b0 || mem_addr[k] !== 14'd0 ||
                mem_wline[k] !== 64'd0 || rd_line[k] !== 64'd0) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b en=%b we=%b icd=%b dcd=%b addr=%h wline=%h rd=%h, expected all zero",
                         k, busy[k], mem_en[k], mem_we[k], ic_done[k], dc_done[k], mem_addr[k], mem_wline[k], rd_line[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_icache_read();
        reset_all();
        ic_addr[1] = 16'h0046;
        ic_req[1]  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en[1] !== (c <= 2) || busy[1] !== (c <= 3) || ic_done[1] !== (c == 3) || dc_done[1] !== 1'b0) begin
                errors++;
                $display("FAIL icache_read cycle %0d: en=%b busy=%b icd=%b dcd=%b, expected en=%b busy=%b icd=%b dcd=0",
                         c, mem_en[1], busy[1], ic_done[1], dc_done[1], c <= 2, c <= 3, c == 3);
            end
            if (c <= 2) begin
                checks++;
                if (mem_addr[1] !== 14'h0011 || mem_we[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL icache_read addr cycle %0d: addr=%h we=%b, expected addr=0011 we=0", c, mem_addr[1], mem_we[1]);
                end
            end
            if (c == 3) begin
                checks++;
                if (rd_line[1] !== mdl_rd(1, 14'h0011)) begin
                    errors++;
                    $display("FAIL icache_read data: rd_line=%h, expected %h", rd_line[1], mdl_rd(1, 14'h0011));
                end
                ic_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_dc_write();
        dc_addr[1]  = 16'h0100;
        dc_wline[1] = 64'hDEAD_BEEF_0000_0001;
        dc_we[1]    = 1'b1;
        dc_req[1]   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en[1] !== (c <= 2) || busy[1] !== (c <= 3) || dc_done[1] !== (c == 3) || ic_done[1] !== 1'b0) begin
                errors++;
                $display("FAIL dc_write cycle %0d: en=%b busy=%b dcd=%b icd=%b, expected en=%b busy=%b dcd=%b icd=0",
                         c, mem_en[1], busy[1], dc_done[1], ic_done[1], c <= 2, c <= 3, c == 3);
            end
            if (c <= 2) begin
                checks++;
                if (mem_we[1] !== 1'b1 || mem_addr[1] !== 14'h0040 || mem_wline[1] !== 64'hDEAD_BEEF_0000_0001) begin
                    errors++;
                    $display("FAIL dc_write bus cycle %0d: we=%b addr=%h wline=%h, expected we=1 addr=0040 wline=deadbeef00000001",
                             c, mem_we[1], mem_addr[1], mem_wline[1]);
                end
            end
            if (c == 3) begin
                checks++;
                if (rd_line[1] !== mdl_rd(1, 14'h0011)) begin
                    errors++;
                    $display("FAIL dc_write rd_line: rd_line=%h, expected unchanged %h", rd_line[1], mdl_rd(1, 14'h0011));
                end
                dc_req[1] = 1'b0;
                dc_we[1]  = 1'b0;
                mdl_mem[1][8'h40] = 64'hDEAD_BEEF_0000_0001;
                mdl_v[1][8'h40]   = 1'b1;
            end
        end
        dc_req[1] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (dc_done[1] !== 1'b1 || rd_line[1] !== 64'hDEAD_BEEF_0000_0001) begin
                    errors++;
                    $display("FAIL dc_readback: dcd=%b rd_line=%h, expected dcd=1 rd_line=deadbeef00000001", dc_done[1], rd_line[1]);
                end
                dc_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_simultaneous();
        int exp_ic = RR ? 3 : 7;
        int exp_dc = RR ? 7 : 3;
        reset_all();
        ic_addr[1] = 16'h0008;
        dc_addr[1] = 16'h0010;
        ic_req[1]  = 1'b1;
        dc_req[1]  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (ic_done[1] !== (c == exp_ic) || dc_done[1] !== (c == exp_dc) || busy[1] !== (c != 4 && c != 8)) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: icd=%b dcd=%b busy=%b, expected icd=%b dcd=%b busy=%b",
                         c, ic_done[1], dc_done[1], busy[1], c == exp_ic, c == exp_dc, c != 4 && c != 8);
            end
            if (c == exp_ic || c == exp_dc) begin
                checks++;
                if (rd_line[1] !== mdl_rd(1, c == exp_ic ? 14'h0002 : 14'h0004)) begin
                    errors++;
                    $display("FAIL simultaneous data cycle %0d: rd_line=%h, expected %h",
                             c, rd_line[1], mdl_rd(1, c == exp_ic ? 14'h0002 : 14'h0004));
                end
                if (c == exp_ic) ic_req[1] = 1'b0;
                else dc_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_hold_both();
        reset_all();
        ic_addr[1] = 16'h0030;
        dc_addr[1] = 16'h0034;
        ic_req[1]  = 1'b1;
        dc_req[1]  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            bit dcn;
            @(negedge clk);
            dcn = RR ? ((c - 1) / 4) % 2 == 1 : 1'b1;
            checks++;
            if (ic_done[1] !== (c % 4 == 3 && !dcn) || dc_done[1] !== (c % 4 == 3 && dcn) || busy[1] !== (c % 4 != 0)) begin
                errors++;
                $display("FAIL hold_both cycle %0d: icd=%b dcd=%b busy=%b, expected icd=%b dcd=%b busy=%b",
                         c, ic_done[1], dc_done[1], busy[1], c % 4 == 3 && !dcn, c % 4 == 3 && dcn, c % 4 != 0);
            end
            if (c == 15) begin
                ic_req[1] = 1'b0;
                dc_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_all();
        ic_addr[2] = 16'h0020;
        ic_req[2]  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en[2] !== (c <= 3) || ic_done[2] !== (c == 4)) begin
                errors++;
                $display("FAIL reset_mid pre cycle %0d: en=%b icd=%b, expected en=%b icd=%b", c, mem_en[2], ic_done[2], c <= 3, c == 4);
            end
            if (c == 4) begin
                checks++;
                if (rd_line[2] !== mdl_rd(2, 14'h0008)) begin
                    errors++;
                    $display("FAIL reset_mid pre data: rd_line=%h, expected %h", rd_line[2], mdl_rd(2, 14'h0008));
                end
                ic_req[2] = 1'b0;
            end
        end
        ic_addr[2] = 16'h0024;
        ic_req[2]  = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_en[2] !== 1'b1 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid busy2: en=%b busy=%b, expected en=1 busy=1", mem_en[2], busy[2]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0 || mem_en[2] !== 1'b0 || ic_done[2] !== 1'b0 || rd_line[2] !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid after: busy=%b en=%b icd=%b rd_line=%h, expected all zero", busy[2], mem_en[2], ic_done[2], rd_line[2]);
        end
        rst_n     = 1'b1;
        ic_req[2] = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (ic_done[2] !== 1'b0 || mem_en[2] !== 1'b0 || busy[2] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid quiet cycle %0d: icd=%b en=%b busy=%b, expected 0 0 0", c, ic_done[2], mem_en[2], busy[2]);
            end
        end
    endtask

    task automatic test_latency1();
        logic [15:0] a = 16'($urandom) & 16'h03FF;
        reset_all();
        ic_addr[0] = a;
        ic_req[0]  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en[0] !== (c == 1) || busy[0] !== (c <= 2) || ic_done[0] !== (c == 2)) begin
                errors++;
                $display("FAIL latency1 cycle %0d: en=%b busy=%b icd=%b, expected en=%b busy=%b icd=%b",
                         c, mem_en[0], busy[0], ic_done[0], c == 1, c <= 2, c == 2);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr[0] !== a[15:2]) begin
                    errors++;
                    $display("FAIL latency1 addr: mem_addr=%h, expected %h", mem_addr[0], a[15:2]);
                end
            end
            if (c == 2) begin
                checks++;
                if (rd_line[0] !== mdl_rd(0, a[15:2])) begin
                    errors++;
                    $display("FAIL latency1 data: rd_line=%h, expected %h", rd_line[0], mdl_rd(0, a[15:2]));
                end
                ic_req[0] = 1'b0;
            end
        end
    endtask

    // Transaction model: a grant in an idle cycle g occupies the memory for cycles g+1..g+L
    // and answers in cycle g+L+1; the cycle after that is idle again.
    task automatic test_random(int s, int ncyc);
        int          l = s + 1;
        int          g = 0;
        bit          act = 1'b0, own_dc = 1'b0, m_we = 1'b0, last_dc = 1'b1, ic_p = 1'b0, dc_p = 1'b0;
        logic [13:0] m_line = '0;
        logic [63:0] m_wline = '0, m_rd = '0;
        reset_all();
        for (int c = 0; c < ncyc; c++) begin
            int rel;
            bit exp_en, exp_icd, exp_dcd;
            rel     = c - g;
            exp_en  = act && rel <= l;
            exp_icd = act && rel == l + 1 && !own_dc;
            exp_dcd = act && rel == l + 1 && own_dc;
            if (act && rel == l + 1 && !m_we) m_rd = mdl_rd(s, m_line);
            checks++;
            if (mem_en[s] !== exp_en || busy[s] !== act || ic_done[s] !== exp_icd || dc_done[s] !== exp_dcd || rd_line[s] !== m_rd) begin
                errors++;
                $display("FAIL random L=%0d cycle %0d: en=%b busy=%b icd=%b dcd=%b rd=%h, expected en=%b busy=%b icd=%b dcd=%b rd=%h",
                         l, c, mem_en[s], busy[s], ic_done[s], dc_done[s], rd_line[s], exp_en, act, exp_icd, exp_dcd, m_rd);
            end
            if (exp_en) begin
                checks++;
                if (mem_addr[s] !== m_line || mem_we[s] !== m_we || (m_we && mem_wline[s] !== m_wline)) begin
                    errors++;
                    $display("FAIL random bus L=%0d cycle %0d: addr=%h we=%b wline=%h, expected addr=%h we=%b wline=%h",
                             l, c, mem_addr[s], mem_we[s], mem_wline[s], m_line, m_we, m_wline);
                end
            end
            if (!ic_p && $urandom_range(0, 2) == 0) begin
                ic_p       = 1'b1;
                ic_addr[s] = 16'($urandom) & 16'h03FF;
            end
            if (!dc_p) dc_we[s] = 1'($urandom_range(0, 1));
            if (!dc_p && $urandom_range(0, 2) == 0) begin
                dc_p        = 1'b1;
                dc_addr[s]  = 16'($urandom) & 16'h03FF;
                dc_wline[s] = {$urandom, $urandom};
            end
            if (act && rel == l + 1) begin
                act = 1'b0;
                if (m_we) begin
                    mdl_mem[s][m_line[7:0]] = m_wline;
                    mdl_v[s][m_line[7:0]]   = 1'b1;
                end
                if ($urandom_range(0, 3) != 0) begin
                    if (own_dc) dc_p = 1'b0;
                    else ic_p = 1'b0;
                end
            end else if (!act && (ic_p || dc_p)) begin
                if (ic_p && dc_p) own_dc = RR ? !last_dc : 1'b1;
                else own_dc = dc_p;
                last_dc = own_dc;
                act     = 1'b1;
                g       = c;
                m_we    = own_dc && dc_we[s];
                m_line  = own_dc ? dc_addr[s][15:2] : ic_addr[s][15:2];
                m_wline = dc_wline[s];
            end
            ic_req[s] = ic_p;
            dc_req[s] = dc_p;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_icache_read();
        test_dc_write();
        test_simultaneous();
        test_hold_both();
        test_reset_mid();
        test_latency1();
        for (int s = 0; s < 3; s++) test_random(s, 400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
